// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Program-counter sequencer for a MIPS-style fetch stage. It holds the
//   current PC and picks the next one from exception, jump-register, jump,
//   branch or sequential (pc+4) sources. A small BOOT/RUN/STALL/HALT state
//   machine decides when the PC may advance.
//
// Parameters:
//   ADDR_W     PC/address width, legal range 28..32 (default 32)
//   RESET_VEC  PC value loaded while rst_n is low (default 0)
//   EXC_VEC    exception target (default 0x180, truncated to ADDR_W)
//
// Optional feature (compile-time macro):
//   PC_ALIGN_CHECK_EN  when defined, a jr target whose low two bits are not
//                      zero is redirected to EXC_VEC and sets illegal_ctl.
//                      When undefined, rs_data is loaded unchanged.
//
// Ports:
//   clk          in   1       clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   stall        in   1       hold PC this cycle
//   halt         in   1       enter HALT state
//   exc          in   1       exception request
//   j            in   1       jump
//   jal          in   1       jump and link
//   jr           in   1       jump register
//   br           in   1       branch instruction present
//   br_taken     in   1       branch condition true
//   instruction  in   32      current instruction (target/offset fields)
//   rs_data      in   ADDR_W  jr target
//   pc           out  ADDR_W  current PC
//   last_pc      out  ADDR_W  PC before the last advance
//   link_addr    out  ADDR_W  pc+4, combinational
//   pc_valid     out  1       pc holds a fetchable address (RUN/STALL)
//   illegal_ctl  out  1       sticky illegal-control-combination flag
//   adv_count    out  32      number of PC advances (wraps at 2^32)
// ============================================================================

module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0180)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              halt,
    input  logic              exc,
    input  logic              j,
    input  logic              jal,
    input  logic              jr,
    input  logic              br,
    input  logic              br_taken,
    input  logic [31:0]       instruction,
    input  logic [ADDR_W-1:0] rs_data,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] last_pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic              pc_valid,
    output logic              illegal_ctl,
    output logic [31:0]       adv_count
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_last_pc;
    logic [31:0]       r_adv_count;
    logic              r_illegal;

    // ------------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------------
    logic [1:0]        w_state_next;
    logic              w_advance;       // PC updates on this edge
    logic [ADDR_W-1:0] w_pc_next;       // value loaded when w_advance
    logic              w_set_illegal;   // set the sticky flag on this edge

    logic [ADDR_W-1:0] w_link;          // pc + 4
    logic [ADDR_W-1:0] w_jump_tgt;      // j/jal target
    logic [ADDR_W-1:0] w_br_off;        // sign-extended, word-scaled offset
    logic [ADDR_W-1:0] w_br_tgt;        // branch target
    logic [ADDR_W-1:0] w_ctl_pc;        // next PC chosen by control inputs
    logic              w_ctl_illegal;   // control inputs form an illegal mix
    logic              w_unused;

    // Opcode bits are not needed: the decode happens upstream and arrives as
    // the j/jal/jr/br strobes.
    assign w_unused = ^instruction[31:26];

    // ------------------------------------------------------------------------
    // Address arithmetic. Every sum is ADDR_W wide so wrap-around is simply
    // the natural carry-out being dropped.
    // ------------------------------------------------------------------------
    assign w_link = r_pc + ADDR_W'(4);

    // Jump target keeps the 256 MB region of the delay-slot address (pc+4).
    // With a 28-bit PC there is no region field, so only the 28-bit
    // pseudo-direct address remains.
    generate
        if (ADDR_W > 28) begin : g_jump_region
            assign w_jump_tgt = {w_link[ADDR_W-1:28], instruction[25:0], 2'b00};
        end else begin : g_jump_flat
            assign w_jump_tgt = {instruction[25:0], 2'b00};
        end
    endgenerate

    // ADDR_W >= 28, so the replication count below is always positive.
    assign w_br_off = {{(ADDR_W-18){instruction[15]}}, instruction[15:0], 2'b00};
    assign w_br_tgt = w_link + w_br_off;

    // ------------------------------------------------------------------------
    // Next-PC selection from control inputs (exception handled separately in
    // the FSM because it also applies in HALT). First match wins:
    //   jr with j/jal  -> pc+4, flag illegal
    //   jr             -> rs_data (optionally alignment-checked)
    //   j / jal        -> jump target
    //   br & br_taken  -> branch target
    //   otherwise      -> pc+4
    // A branch alongside a jump is a normal delay-slot situation: the jump
    // wins silently.
    // ------------------------------------------------------------------------
    always_comb begin
        w_ctl_pc      = w_link;
        w_ctl_illegal = 1'b0;
        if (jr && (j || jal)) begin
            w_ctl_pc      = w_link;
            w_ctl_illegal = 1'b1;
        end else if (jr) begin
`ifdef PC_ALIGN_CHECK_EN
            if (rs_data[1:0] != 2'b00) begin
                w_ctl_pc      = EXC_VEC;
                w_ctl_illegal = 1'b1;
            end else begin
                w_ctl_pc = rs_data;
            end
`else
            w_ctl_pc = rs_data;
`endif
        end else if (j || jal) begin
            w_ctl_pc = w_jump_tgt;
        end else if (br && br_taken) begin
            w_ctl_pc = w_br_tgt;
        end
    end

    // ------------------------------------------------------------------------
    // State machine / advance decision.
    // RUN and STALL share the same decision tree: an exception always
    // advances to EXC_VEC, halt parks the PC, stall holds it, and otherwise
    // the control inputs are acted on. Sharing the tree means the cycle that
    // leaves STALL executes its jump/branch instead of dropping it.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_advance     = 1'b0;
        w_pc_next     = r_pc;
        w_set_illegal = 1'b0;
        case (r_state)
            ST_BOOT: begin
                // Single settle cycle; all inputs including exc are ignored.
                w_state_next = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                if (exc) begin
                    w_state_next = ST_RUN;
                    w_advance    = 1'b1;
                    w_pc_next    = EXC_VEC;
                end else if (halt) begin
                    w_state_next = ST_HALT;
                end else if (stall) begin
                    w_state_next = ST_STALL;
                end else begin
                    w_state_next  = ST_RUN;
                    w_advance     = 1'b1;
                    w_pc_next     = w_ctl_pc;
                    w_set_illegal = w_ctl_illegal;
                end
            end
            ST_HALT: begin
                // Only an exception (or reset) wakes the sequencer.
                if (exc) begin
                    w_state_next = ST_RUN;
                    w_advance    = 1'b1;
                    w_pc_next    = EXC_VEC;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential state. Reset is asynchronous so the PC is pinned to
    // RESET_VEC (and link_addr to RESET_VEC+4) without waiting for a clock.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_VEC;
            r_last_pc   <= RESET_VEC;
            r_adv_count <= 32'd0;
            r_illegal   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_advance) begin
                r_last_pc   <= r_pc;
                r_pc        <= w_pc_next;
                r_adv_count <= r_adv_count + 32'd1;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pc          = r_pc;
    assign last_pc     = r_last_pc;
    assign link_addr   = w_link;
    assign pc_valid    = (r_state == ST_RUN) || (r_state == ST_STALL);
    assign illegal_ctl = r_illegal;
    assign adv_count   = r_adv_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer
// ----------------------------------------------------------------------------
// Directed self-checking bench for pc_sequencer (default parameters:
// ADDR_W=32, RESET_VEC=0, EXC_VEC=0x180). Inputs change one time unit after
// a rising edge; outputs are sampled at that same point, i.e. after the edge
// has settled. Honors PC_ALIGN_CHECK_EN for the misaligned-jr expectations.
// ============================================================================

module tb_pc_sequencer;

    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              halt;
    logic              exc;
    logic              j;
    logic              jal;
    logic              jr;
    logic              br;
    logic              br_taken;
    logic [31:0]       instruction;
    logic [ADDR_W-1:0] rs_data;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] last_pc;
    logic [ADDR_W-1:0] link_addr;
    logic              pc_valid;
    logic              illegal_ctl;
    logic [31:0]       adv_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_pc;
    logic        exp_ill;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .halt        (halt),
        .exc         (exc),
        .j           (j),
        .jal         (jal),
        .jr          (jr),
        .br          (br),
        .br_taken    (br_taken),
        .instruction (instruction),
        .rs_data     (rs_data),
        .pc          (pc),
        .last_pc     (last_pc),
        .link_addr   (link_addr),
        .pc_valid    (pc_valid),
        .illegal_ctl (illegal_ctl),
        .adv_count   (adv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        stall = 0; halt = 0; exc = 0; j = 0; jal = 0; jr = 0;
        br = 0; br_taken = 0; instruction = '0; rs_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // ---- reset state ----
        #2;
        check("rst_pc", pc, 64'h0);
        check("rst_last_pc", last_pc, 64'h0);
        check("rst_adv", adv_count, 64'd0);
        check("rst_valid", pc_valid, 64'd0);
        check("rst_ill", illegal_ctl, 64'd0);
        check("rst_link", link_addr, 64'h4);
        @(posedge clk);
        @(posedge clk);
        #4 rst_n = 1'b1;
        #1;
        check("boot_valid", pc_valid, 64'd0);
        check("boot_pc", pc, 64'h0);

        // ---- idle run: 0, 4, 8 ----
        step();
        check("run0_pc", pc, 64'h0);
        check("run0_valid", pc_valid, 64'd1);
        check("run0_adv", adv_count, 64'd0);
        step();
        check("run1_pc", pc, 64'h4);
        check("run1_adv", adv_count, 64'd1);
        step();
        check("run2_pc", pc, 64'h8);
        check("run2_last", last_pc, 64'h4);
        check("run2_adv", adv_count, 64'd2);
        $display("idle run: pc=%0h adv=%0d", pc, adv_count);

        // ---- jr to 0x00400010 ----
        jr = 1; rs_data = 32'h0040_0010;
        step();
        jr = 0;
        check("jr_pc", pc, 64'h0040_0010);
        check("jr_last", last_pc, 64'h8);
        check("jr_adv", adv_count, 64'd3);
        $display("jr: pc=%0h", pc);

        // ---- j with instr[25:0]=0x0100000 ----
        j = 1; instruction = 32'h0010_0000;
        step();
        j = 0;
        check("j_pc", pc, 64'h0040_0000);
        check("j_last", last_pc, 64'h0040_0010);
        check("j_adv", adv_count, 64'd4);
        $display("j: pc=%0h last=%0h", pc, last_pc);

        // ---- branch at 0x100 with imm=-1 ----
        jr = 1; rs_data = 32'h0000_0100;
        step();
        jr = 0;
        check("jr100_pc", pc, 64'h100);
        br = 1; br_taken = 1; instruction = 32'h0000_FFFF;
        step();
        check("br_taken_pc", pc, 64'h100);
        check("br_taken_last", last_pc, 64'h100);
        check("br_taken_adv", adv_count, 64'd6);
        br_taken = 0;
        step();
        br = 0;
        check("br_not_pc", pc, 64'h104);
        check("br_not_adv", adv_count, 64'd7);
        $display("branch: pc=%0h adv=%0d", pc, adv_count);

        // ---- stall 3 cycles with j pending, jump on release ----
        stall = 1; j = 1; instruction = 32'h0000_0040;
        step();
        check("stall1_pc", pc, 64'h104);
        check("stall1_valid", pc_valid, 64'd1);
        step();
        check("stall2_pc", pc, 64'h104);
        step();
        check("stall3_pc", pc, 64'h104);
        check("stall3_adv", adv_count, 64'd7);
        check("stall3_last", last_pc, 64'h100);
        stall = 0;
        step();
        j = 0;
        check("unstall_pc", pc, 64'h100);
        check("unstall_last", last_pc, 64'h104);
        check("unstall_adv", adv_count, 64'd8);
        check("unstall_ill", illegal_ctl, 64'd0);
        $display("stall release: pc=%0h adv=%0d", pc, adv_count);

        // ---- branch together with jump: jump wins, no illegal ----
        br = 1; br_taken = 1; j = 1; instruction = 32'h0000_0080;
        step();
        br = 0; br_taken = 0; j = 0;
        check("brj_pc", pc, 64'h200);
        check("brj_ill", illegal_ctl, 64'd0);

        // ---- misaligned jr ----
        jr = 1; rs_data = 32'h0000_1002;
        step();
        jr = 0;
`ifdef PC_ALIGN_CHECK_EN
        exp_pc = 32'h0000_0180; exp_ill = 1'b1;
`else
        exp_pc = 32'h0000_1002; exp_ill = 1'b0;
`endif
        check("misal_pc", pc, {32'h0, exp_pc});
        check("misal_ill", illegal_ctl, {63'h0, exp_ill});
        check("misal_adv", adv_count, 64'd10);
        $display("misaligned jr: pc=%0h ill=%0d", pc, illegal_ctl);

        // ---- jr + jal together: pc+4, illegal sticky ----
        jr = 1; jal = 1; rs_data = 32'h0000_2000;
        exp_pc = exp_pc + 32'd4;
        step();
        jr = 0; jal = 0;
        check("jrjal_pc", pc, {32'h0, exp_pc});
        check("jrjal_ill", illegal_ctl, 64'd1);
        check("jrjal_adv", adv_count, 64'd11);
        exp_pc = exp_pc + 32'd4;
        step();
        check("jrjal_next_pc", pc, {32'h0, exp_pc});
        check("jrjal_sticky", illegal_ctl, 64'd1);
        $display("jr+jal: pc=%0h ill=%0d", pc, illegal_ctl);

        // ---- halt: pc frozen, valid low, jump ignored ----
        halt = 1;
        step();
        halt = 0;
        check("halt_pc", pc, {32'h0, exp_pc});
        check("halt_valid", pc_valid, 64'd0);
        j = 1; instruction = 32'h0000_0400;
        step();
        j = 0;
        check("halt_j_pc", pc, {32'h0, exp_pc});
        check("halt_adv", adv_count, 64'd12);

        // ---- exception from HALT ----
        exc = 1;
        step();
        exc = 0;
        check("exc_halt_pc", pc, 64'h180);
        check("exc_halt_last", last_pc, {32'h0, exp_pc});
        check("exc_halt_valid", pc_valid, 64'd1);
        check("exc_halt_adv", adv_count, 64'd13);
        step();
        check("exc_run_pc", pc, 64'h184);
        $display("exc from halt: pc=%0h", pc);

        // ---- exception overrides stall ----
        stall = 1; exc = 1;
        step();
        exc = 0;
        check("exc_stall_pc", pc, 64'h180);
        check("exc_stall_adv", adv_count, 64'd15);
        stall = 0;
        step();
        check("post_exc_pc", pc, 64'h184);

        // ---- reset mid-stall with a pending jump ----
        stall = 1; j = 1; instruction = 32'h0000_0400;
        step();
        check("pre_rst_pc", pc, 64'h184);
        rst_n = 1'b0;
        #2;
        check("mid_rst_pc", pc, 64'h0);
        check("mid_rst_last", last_pc, 64'h0);
        check("mid_rst_adv", adv_count, 64'd0);
        check("mid_rst_ill", illegal_ctl, 64'd0);
        check("mid_rst_valid", pc_valid, 64'd0);
        check("mid_rst_link", link_addr, 64'h4);
        stall = 0; j = 0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_boot_pc", pc, 64'h0);
        check("rst2_valid", pc_valid, 64'd1);
        $display("reset mid-stall: pc=%0h adv=%0d", pc, adv_count);

        // ---- backward branch from 0 wraps ----
        br = 1; br_taken = 1; instruction = 32'h0000_FFFE;
        step();
        br = 0; br_taken = 0;
        check("wrap_br_pc", pc, 64'hFFFF_FFFC);
        step();
        check("wrap_inc_pc", pc, 64'h0);
        check("wrap_adv", adv_count, 64'd2);
        $display("wrap: pc=%0h adv=%0d", pc, adv_count);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the PC/address width; legal range is 28..32.
REQ-002 The block SHALL have parameter RESET_VEC, default 0, giving the PC loaded by reset.
REQ-003 The block SHALL have parameter EXC_VEC, default 32'h00000180 truncated to ADDR_W, giving the exception target.
REQ-004 The block SHALL have the following ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active low
stall  in  1  hold PC this cycle
halt  in  1  enter HALT state
exc  in  1  exception request
j  in  1  jump
jal  in  1  jump and link
jr  in  1  jump register
br  in  1  branch instruction present
br_taken  in  1  branch condition true
instruction  in  32  current instruction
rs_data  in  ADDR_W  jr target
pc  out  ADDR_W  current PC
last_pc  out  ADDR_W  PC before last advance
link_addr  out  ADDR_W  pc+4, combinational
pc_valid  out  1  pc holds a fetchable address
illegal_ctl  out  1  sticky illegal-control flag
adv_count  out  32  count of PC advances

Function
REQ-005 The block SHALL implement states BOOT, RUN, STALL and HALT.
REQ-006 BOOT SHALL last exactly one cycle after rst_n deasserts, with pc=RESET_VEC and pc_valid=0, then go to RUN.
REQ-007 In RUN, the next state SHALL be HALT if halt=1 and exc=0, else STALL if stall=1 and exc=0, else RUN.
REQ-008 STALL SHALL return to RUN on the first cycle with stall=0, or on exc=1; halt=1 in STALL SHALL go to HALT.
REQ-009 HALT SHALL be left only by exc=1 (to RUN, loading EXC_VEC) or by reset.
REQ-010 pc_valid SHALL be 1 in RUN and STALL and 0 in BOOT and HALT.
REQ-011 In RUN with no stall or halt, the next pc SHALL be chosen by first match: exc -> EXC_VEC; jr alone -> rs_data; j or jal (jr=0) -> jump target; br and br_taken -> branch target; otherwise pc+4.
REQ-012 The jump target SHALL be {link_addr[ADDR_W-1:28], instruction[25:0], 2'b00}; at ADDR_W=28 it SHALL be the lower 28 bits only.
REQ-013 The branch target SHALL be link_addr + (sign-extended instruction[15:0] << 2), modulo 2^ADDR_W.
REQ-014 All PC arithmetic SHALL wrap modulo 2^ADDR_W without flagging.
REQ-015 If jr=1 together with j=1 or jal=1, the next pc SHALL be pc+4 and illegal_ctl SHALL set and hold until reset.
REQ-016 If br=1 together with j, jal or jr, the jump SHALL win, and illegal_ctl SHALL NOT set.
REQ-017 exc SHALL take effect in every state except BOOT, overriding stall and halt in the same cycle.
REQ-018 On every pc update (advance), last_pc SHALL take the old pc on the same rising edge.
REQ-019 On every advance, adv_count SHALL increment by 1, wrapping at 2^32.
REQ-020 In STALL and HALT, pc, last_pc and adv_count SHALL hold their values.
REQ-021 Control inputs in the cycle that leaves STALL SHALL be acted upon in that cycle, so that no jump is lost.
REQ-022 The update latency SHALL be one clock: a decision sampled at edge N SHALL be visible on pc after edge N.

Reset
REQ-023 rst_n=0 SHALL immediately force pc=RESET_VEC, last_pc=RESET_VEC, adv_count=0, illegal_ctl=0, pc_valid=0 and state=BOOT, regardless of clk.
REQ-024 Reset asserted mid-stall or mid-HALT SHALL discard all pending control inputs.
REQ-025 link_addr SHALL equal RESET_VEC+4 during reset.

Configuration
REQ-026 With macro PC_ALIGN_CHECK_EN defined, a jr target with rs_data[1:0] != 0 SHALL load EXC_VEC instead of rs_data and SHALL set illegal_ctl.
REQ-027 Without PC_ALIGN_CHECK_EN, rs_data SHALL be loaded unchanged, and misalignment SHALL NOT affect illegal_ctl.

Verification
REQ-028 The bench SHALL cover reset release followed by idle inputs -> pc 0, 0, 4, 8 over successive edges, with pc_valid 0 for one cycle then 1.
REQ-029 The bench SHALL cover pc=0x00400010 with j and instruction[25:0]=0x0100000 -> pc=0x00400000, last_pc=0x00400010, adv_count+1.
REQ-030 The bench SHALL cover pc=0x100 with br=1, br_taken=1 and imm=0xFFFF -> pc=0x100; with br_taken=0 -> pc=0x104.
REQ-031 The bench SHALL cover stall held for 3 cycles with j asserted -> pc frozen; jump taken on the cycle stall drops.
REQ-032 The bench SHALL cover jr=1 and jal=1 together -> pc+4 and illegal_ctl=1 persisting; then exc in HALT -> pc=EXC_VEC, state RUN.
REQ-033 The bench SHALL cover PC_ALIGN_CHECK_EN defined with jr and rs_data=0x1002 -> pc=EXC_VEC and illegal_ctl=1; with the macro undefined -> pc=0x1002.
